// File: rtl/denise_colortable_pkg.sv
// Shared types for the Denise colour table controller: FSM states and the
// pending-write queue entry. Queue entry fields are sized for the largest
// supported table (256 entries) and the native 12-bit colour width.
package denise_colortable_pkg;

    localparam int WQ_AW_MAX = 8;
    localparam int WQ_CW_MAX = 12;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [WQ_AW_MAX-1:0] addr;
        logic [WQ_CW_MAX-1:0] data;
        logic                 loct;
    } wq_entry_t;

endpackage

// File: rtl/denise_colortable_wq.sv
// Pending colour-write queue with an address lookup. The lookup folds every
// queued entry that matches the lookup address onto the palette value,
// oldest first, so a read sees writes that have not yet reached the arrays.
module denise_colortable_wq
    import denise_colortable_pkg::*;
#(
    parameter int AW     = 8,
    parameter int CW     = 12,
    parameter int QDEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic [AW-1:0] i_push_addr,
    input  logic [CW-1:0] i_push_data,
    input  logic          i_push_loct,
    input  logic          i_pop,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW-1:0] o_head_addr,
    output logic [CW-1:0] o_head_data,
    output logic          o_head_loct,
    input  logic [AW-1:0] i_lk_addr,
    output logic          o_lk_hi_hit,
    output logic          o_lk_lo_hit,
    output logic [CW-1:0] o_lk_hi_data,
    output logic [CW-1:0] o_lk_lo_data
);

    localparam int PW   = $clog2(QDEPTH);
    localparam int CNTW = PW + 1;

    wq_entry_t       r_q [QDEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CNTW-1:0] r_count;
    wq_entry_t       w_head;
    logic            w_do_push;
    logic            w_do_pop;
    logic [PW-1:0]   w_idx;

    assign o_full      = (r_count == CNTW'(QDEPTH));
    assign o_empty     = (r_count == '0);
    assign w_do_push   = i_push & ~o_full;
    assign w_do_pop    = i_pop & ~o_empty;
    assign w_head      = r_q[r_rd_ptr];
    assign o_head_addr = w_head.addr[AW-1:0];
    assign o_head_data = w_head.data[CW-1:0];
    assign o_head_loct = w_head.loct;

    // Pointer and occupancy tracking; pointers wrap naturally at QDEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are qualified by the occupancy count.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_q[r_wr_ptr] <= '{addr: WQ_AW_MAX'(i_push_addr),
                               data: WQ_CW_MAX'(i_push_data),
                               loct: i_push_loct};
        end
    end

    // Overlay lookup: walk oldest to newest so the newest match wins per half.
    always_comb begin
        o_lk_hi_hit  = 1'b0;
        o_lk_lo_hit  = 1'b0;
        o_lk_hi_data = '0;
        o_lk_lo_data = '0;
        w_idx        = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            w_idx = r_rd_ptr + PW'(i);
            if ((CNTW'(i) < r_count) && (r_q[w_idx].addr == WQ_AW_MAX'(i_lk_addr))) begin
                o_lk_lo_hit  = 1'b1;
                o_lk_lo_data = r_q[w_idx].data[CW-1:0];
                if (!r_q[w_idx].loct) begin
                    o_lk_hi_hit  = 1'b1;
                    o_lk_hi_data = r_q[w_idx].data[CW-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/denise_colortable_ctrl.sv
// Denise colour table: two CW-wide planes (high/low) sharing one address,
// cleared by a sweep after reset, written through a small queue that drains
// only when the lookup port is idle. Reads overlay queued writes.
module denise_colortable_ctrl
    import denise_colortable_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int CW     = 12,
    parameter int QDEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [CW-1:0]            wr_data,
    input  logic                     wr_loct,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [2*CW-1:0]          rd_data,
    output logic                     rd_valid,
    output logic                     init_busy
);

    localparam int AW = $clog2(DEPTH);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_init_cnt;
    logic          w_init;
    logic          w_run;

    logic [CW-1:0] r_mem_hi [DEPTH];
    logic [CW-1:0] r_mem_lo [DEPTH];
    logic [CW-1:0] r_hi_q;
    logic [CW-1:0] r_lo_q;

    logic          r_rd_valid;
    logic          r_rd_init;
    logic          r_ov_hi_hit;
    logic          r_ov_lo_hit;
    logic [CW-1:0] r_ov_hi_data;
    logic [CW-1:0] r_ov_lo_data;

    logic          w_q_full;
    logic          w_q_empty;
    logic [AW-1:0] w_head_addr;
    logic [CW-1:0] w_head_data;
    logic          w_head_loct;
    logic          w_lk_hi_hit;
    logic          w_lk_lo_hit;
    logic [CW-1:0] w_lk_hi_data;
    logic [CW-1:0] w_lk_lo_data;

    logic          w_push;
    logic          w_pop;
    logic [AW-1:0] w_port_addr;
    logic          w_hi_we;
    logic          w_lo_we;
    logic [CW-1:0] w_wdata;
    logic [CW-1:0] w_hi_out;
    logic [CW-1:0] w_lo_out;

    denise_colortable_wq #(
        .AW     (AW),
        .CW     (CW),
        .QDEPTH (QDEPTH)
    ) u_wq (
        .clk          (clk),
        .reset        (reset),
        .i_push       (w_push),
        .i_push_addr  (wr_addr),
        .i_push_data  (wr_data),
        .i_push_loct  (wr_loct),
        .i_pop        (w_pop),
        .o_full       (w_q_full),
        .o_empty      (w_q_empty),
        .o_head_addr  (w_head_addr),
        .o_head_data  (w_head_data),
        .o_head_loct  (w_head_loct),
        .i_lk_addr    (rd_addr),
        .o_lk_hi_hit  (w_lk_hi_hit),
        .o_lk_lo_hit  (w_lk_lo_hit),
        .o_lk_hi_data (w_lk_hi_data),
        .o_lk_lo_data (w_lk_lo_data)
    );

    // Next-state logic: sweep every address once, then run.
    always_comb begin
        w_state_nxt = r_state;
        w_init      = 1'b0;
        w_run       = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_init = 1'b1;
                if (r_init_cnt == AW'(DEPTH - 1)) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_run = 1'b1;
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    assign init_busy = w_init;
    assign wr_ready  = w_run & ~w_q_full;
    assign w_push    = wr_valid & wr_ready;
    assign w_pop     = w_run & ~rd_en & ~w_q_empty;

    // The single array port serves the sweep, then lookups, then the drain.
    assign w_port_addr = w_init ? r_init_cnt : (rd_en ? rd_addr : w_head_addr);
    assign w_hi_we     = w_init | (w_pop & ~w_head_loct);
    assign w_lo_we     = w_init | w_pop;
    assign w_wdata     = w_init ? '0 : w_head_data;

    // State register and clear-sweep address counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_init) r_init_cnt <= r_init_cnt + 1'b1;
        end
    end

    // Read qualification: a lookup issued during the sweep returns zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_init  <= 1'b1;
        end else begin
            r_rd_valid <= rd_en;
            r_rd_init  <= w_init;
        end
    end

    // Palette planes (read-first) and the queue overlay captured with the read.
    always_ff @(posedge clk) begin
        if (w_hi_we) r_mem_hi[w_port_addr] <= w_wdata;
        if (w_lo_we) r_mem_lo[w_port_addr] <= w_wdata;
        r_hi_q       <= r_mem_hi[w_port_addr];
        r_lo_q       <= r_mem_lo[w_port_addr];
        r_ov_hi_hit  <= w_lk_hi_hit;
        r_ov_lo_hit  <= w_lk_lo_hit;
        r_ov_hi_data <= w_lk_hi_data;
        r_ov_lo_data <= w_lk_lo_data;
    end

    assign w_hi_out = r_ov_hi_hit ? r_ov_hi_data : r_hi_q;
    assign w_lo_out = r_ov_lo_hit ? r_ov_lo_data : r_lo_q;
    assign rd_valid = r_rd_valid;
    assign rd_data  = (r_rd_valid & ~r_rd_init) ? {w_hi_out, w_lo_out} : '0;

endmodule

// File: tb/tb_denise_colortable_ctrl.sv
// Bench for denise_colortable_ctrl: directed scenarios plus random traffic,
// all checked cycle by cycle against a palette/queue reference model.
module tb_denise_colortable_ctrl;

    localparam int DEPTH  = 256;
    localparam int CW     = 12;
    localparam int QDEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_addr;
    logic [11:0] wr_data;
    logic        wr_loct;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [23:0] rd_data;
    logic        rd_valid;
    logic        init_busy;

    denise_colortable_ctrl #(
        .DEPTH  (DEPTH),
        .CW     (CW),
        .QDEPTH (QDEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_loct   (wr_loct),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .init_busy (init_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
        bit loct;
    } ent_t;

    int   n_checks = 0;
    int   n_errors = 0;
    int   m_hi [DEPTH];
    int   m_lo [DEPTH];
    ent_t m_q [$];
    int   init_left;
    bit   last_acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_ready();
        return (init_left == 0) && (m_q.size() < QDEPTH);
    endfunction

    // Palette value as seen by a reader: arrays with queued writes layered on.
    function automatic logic [23:0] lookup(input int a);
        int hi = m_hi[a];
        int lo = m_lo[a];
        foreach (m_q[i]) begin
            if (m_q[i].addr == a) begin
                lo = m_q[i].data;
                if (!m_q[i].loct) hi = m_q[i].data;
            end
        end
        return {hi[11:0], lo[11:0]};
    endfunction

    task automatic model_reset();
        m_q.delete();
        init_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) begin
            m_hi[i] = 0;
            m_lo[i] = 0;
        end
    endtask

    // One clock: check state-derived outputs, clock, check the read, advance model.
    task automatic tick();
        bit          acc;
        bit          ev;
        logic [23:0] ed;
        ent_t        e;
        check("wr_ready", {31'd0, wr_ready}, {31'd0, exp_ready()});
        check("init_busy", {31'd0, init_busy}, {31'd0, (init_left != 0)});
        acc = wr_valid && exp_ready();
        ev  = rd_en;
        ed  = (rd_en && init_left == 0) ? lookup(int'(rd_addr)) : 24'h0;
        @(posedge clk);
        #1;
        if (reset) begin
            model_reset();
            acc = 1'b0;
            check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
            check("rst_rd_data", {8'd0, rd_data}, 32'd0);
        end else begin
            check("rd_valid", {31'd0, rd_valid}, {31'd0, ev});
            if (ev) check("rd_data", {8'd0, rd_data}, {8'd0, ed});
            if (init_left > 0) begin
                init_left--;
            end else if (!rd_en && m_q.size() > 0) begin
                e = m_q.pop_front();
                m_lo[e.addr] = e.data;
                if (!e.loct) m_hi[e.addr] = e.data;
            end
            if (acc) begin
                e.addr = int'(wr_addr);
                e.data = int'(wr_data);
                e.loct = wr_loct;
                m_q.push_back(e);
            end
        end
        last_acc = acc;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_write(input int a, input int d, input bit l);
        wr_valid = 1'b1;
        wr_addr  = a[7:0];
        wr_data  = d[11:0];
        wr_loct  = l;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (last_acc) break;
        end
        if (!last_acc) check("wr_timeout", 32'd0, 32'd1);
        wr_valid = 1'b0;
    endtask

    task automatic do_read(input string tag, input int a, input logic [23:0] exp);
        rd_en   = 1'b1;
        rd_addr = a[7:0];
        tick();
        rd_en = 1'b0;
        check(tag, {8'd0, rd_data}, {8'd0, exp});
    endtask

    initial begin
        reset    = 1'b1;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_loct  = 1'b0;
        rd_en    = 1'b0;
        rd_addr  = '0;
        @(posedge clk);
        #1;
        model_reset();
        tick();
        reset = 1'b0;

        // Clear sweep, reads during and after it.
        idle(100);
        rd_en = 1'b1; rd_addr = 8'h05; tick(); rd_en = 1'b0;
        idle(DEPTH - 101 + 2);
        do_read("rd_00_init", 8'h00, 24'h000000);
        do_read("rd_ff_init", 8'hFF, 24'h000000);

        // Full and low-only writes.
        do_write(8'h10, 12'hABC, 1'b0);
        idle(3);
        do_read("rd_abcabc", 8'h10, 24'hABCABC);
        do_write(8'h10, 12'h123, 1'b1);
        idle(3);
        do_read("rd_abc123", 8'h10, 24'hABC123);

        // Reads stall the drain; queue fills; overlay returns newest value.
        rd_en = 1'b1; rd_addr = 8'h30;
        for (int w = 0; w < 4; w++) do_write(8'h30, 12'h300 + w, 1'b0);
        wr_valid = 1'b1; wr_addr = 8'h30; wr_data = 12'h3FF; wr_loct = 1'b0;
        idle(3);
        check("full_block", {31'd0, last_acc}, 32'd0);
        check("rd_newest", {8'd0, rd_data}, 32'h00303303);
        rd_en = 1'b0;
        for (int k = 0; k < 8 && !last_acc; k++) tick();
        check("fifth_acc", {31'd0, last_acc}, 32'd1);
        wr_valid = 1'b0;
        idle(5);
        do_read("rd_drained", 8'h30, 24'h3FF3FF);

        // Mixed full/low writes queued behind a stalled drain.
        rd_en = 1'b1; rd_addr = 8'h20;
        do_write(8'h20, 12'h111, 1'b0);
        do_write(8'h20, 12'h222, 1'b1);
        rd_en = 1'b1; rd_addr = 8'h20;
        tick();
        check("rd_mix_queued", {8'd0, rd_data}, 32'h00111222);
        rd_en = 1'b0;
        idle(4);
        do_read("rd_mix_drained", 8'h20, 24'h111222);

        // Random traffic, concentrated on a few addresses to exercise overlay.
        for (int c = 0; c < 3000; c++) begin
            wr_valid = ($urandom_range(0, 99) < 60);
            wr_addr  = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            wr_data  = 12'($urandom);
            wr_loct  = $urandom_range(0, 1) != 0;
            rd_en    = ($urandom_range(0, 99) < ((c % 400) < 50 ? 95 : 40));
            rd_addr  = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            tick();
        end
        wr_valid = 1'b0;
        rd_en    = 1'b0;
        idle(6);

        // Reset with queued writes discards them.
        rd_en = 1'b1; rd_addr = 8'h40;
        for (int w = 0; w < 3; w++) do_write(8'h40 + w, 12'h5A0 + w, 1'b0);
        rd_en = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd_en = 1'b0;
        // Reset again partway through the sweep.
        idle(77);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle(DEPTH + 2);
        do_read("rd_40_after_rst", 8'h40, 24'h000000);
        do_read("rd_42_after_rst", 8'h42, 24'h000000);
        do_read("rd_10_after_rst", 8'h10, 24'h000000);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
